sobel_linebuf_ctrl: RTL
=======================

// Module: sobel_linebuf_ctrl
// PURPOSE
//  Sequences the two 200x8 line-delay FIFOs (fifo0 = row r-1, fifo1 = row r-2) that feed the
//  3x3 Sobel window. Tracks pixel row/col, drives all FIFO wr/rd enables, flags valid windows
//  and their centre coordinates, and drains stale FIFO data after reset, frame end or abort.
//  Sits between the pixel source and the window shift registers / 4-direction Sobel datapath.
// PARAMETERS
//  IMG_W  200  pixels per row; must be 3..200 (FIFO depth)
//  IMG_H  200  rows per frame; must be >= 3
//  CW     8    col/row counter width; 2^CW > max(IMG_W, IMG_H)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous, active-low reset
//  sof          in   1   start of frame; qualifies the pix_valid beat of pixel (0,0)
//  pix_valid    in   1   pixel beat present (pixel data goes straight to fifo0 din / tap0)
//  fifo0_full   in   1   fifo0 status
//  fifo0_empty  in   1   fifo0 status
//  fifo1_full   in   1   fifo1 status
//  fifo1_empty  in   1   fifo1 status
//  fifo0_wr_en  out  1   write incoming pixel to fifo0
//  fifo0_rd_en  out  1   pop fifo0 (row r-1 pixel at fifo0 dout next cycle)
//  fifo1_wr_en  out  1   write fifo0 dout into fifo1
//  fifo1_rd_en  out  1   pop fifo1 (row r-2 pixel at fifo1 dout next cycle)
//  tap_valid    out  1   all three column taps valid this cycle -> shift into window
//  win_valid    out  1   3x3 window complete; Sobel output valid for (win_row, win_col)
//  win_row      out  CW  window centre row
//  win_col      out  CW  window centre col
//  eol          out  1   pulse with last window of a row
//  eof          out  1   pulse with last window of the frame
//  busy         out  1   high in every state except IDLE
//  err          out  1   sticky: overflow/underflow or sof abort
// BEHAVIOUR
//  - States: DRAIN, IDLE, ROW0, ROW1, STREAM. rst_n=0 -> DRAIN, row=col=0, all outputs 0
//    except busy (1 from first post-reset cycle); err cleared.
//  - accept = pix_valid & state in {ROW0,ROW1,STREAM}, or pix_valid & sof in IDLE.
//    pix_valid without sof in IDLE is dropped. In DRAIN all pixels are dropped.
//  - IDLE --(sof&pix_valid)--> ROW0, pixel (0,0) accepted that cycle.
//  - col increments per accept, wraps at IMG_W-1 with row+1; row 0 -> ROW1, row 1 -> STREAM.
//  - Enables (combinational from accept): fifo0_wr_en = accept; fifo0_rd_en = accept & row>=1;
//    fifo1_rd_en = accept & row>=2. fifo1_wr_en = fifo0_rd_en registered 1 cycle (FIFO dout
//    is registered, 1-cycle read latency).
//  - tap_valid = (accept & row>=2) registered 1 cycle; win_valid = tap_valid & col_d>=2, where
//    col_d/row_d are col/row of that accepted pixel; win_col = col_d-1, win_row = row_d-1.
//    Latency: pixel (r,c) accept -> window centred (r-1,c-1) valid next cycle.
//  - eol = win_valid & col_d==IMG_W-1; eof = eol & row_d==IMG_H-1.
//  - Accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN next cycle; row/col reset to 0.
//  - DRAIN: fifo0_rd_en = !fifo0_empty, fifo1_rd_en = !fifo1_empty each cycle; pending delayed
//    fifo1_wr_en still issues (its data discarded later). DRAIN -> IDLE when both empty and no
//    write pending. tap/win outputs 0 in DRAIN.
//  - sof&pix_valid while in ROW0/ROW1/STREAM: abort, pixel dropped, err=1, -> DRAIN.
//    New frame needs a fresh sof in IDLE.
//  - err set on any wr_en while full or rd_en while empty (checked on the issued enables);
//    the offending enable is still driven (FIFO ignores it). err cleared only by rst_n=0 or
//    sof accepted in IDLE.
//  - pix_valid gaps: counters/enables simply hold; no timeout.
// TESTING
//  1 IMG_W=8, IMG_H=4, 32 back-to-back pixels after sof -> 12 win_valid, first centre (1,1)
//    one cycle after pixel (2,2); eol at col 6; eof with (2,6); err=0.
//  2 Same frame, pix_valid 50% random -> identical window sequence and coordinates.
//  3 End-of-frame -> DRAIN empties 8 entries from fifo0 and fifo1, then IDLE, busy falls.
//  4 sof at pixel (2,3) mid-frame -> err=1, DRAIN until FIFOs empty, IDLE; next sof clears err.
//  5 rst_n low for 1 cycle at pixel (3,5) -> DRAIN flushes stale data, IDLE, next frame clean.
//  6 Force fifo1_empty=1 during STREAM -> err=1 on first fifo1_rd_en, stays 1 until reset.

Source files
------------

// File: rtl/sobel_linebuf_ctrl.sv
// sobel_linebuf_ctrl: row/col sequencing and line-FIFO enables for a 3x3 Sobel window
module sobel_linebuf_ctrl #(
    parameter int IMG_W = 200,
    parameter int IMG_H = 200,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sof,
    input  logic          pix_valid,
    input  logic          fifo0_full,
    input  logic          fifo0_empty,
    input  logic          fifo1_full,
    input  logic          fifo1_empty,
    output logic          fifo0_wr_en,
    output logic          fifo0_rd_en,
    output logic          fifo1_wr_en,
    output logic          fifo1_rd_en,
    output logic          tap_valid,
    output logic          win_valid,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          eol,
    output logic          eof,
    output logic          busy,
    output logic          err
);
    typedef enum logic [2:0] {DRAIN, IDLE, ROW0, ROW1, STREAM} state_t;

    state_t        state;
    logic [CW-1:0] row, col;
    logic          active, accept, abort, last_col, last_row, tap_next, win_next, drain_done, err_set;

    assign active      = state == ROW0 || state == ROW1 || state == STREAM;
    assign accept      = pix_valid & (active ? !sof : (state == IDLE) & sof);
    assign abort       = pix_valid & sof & active;
    assign last_col    = col == CW'(IMG_W - 1);
    assign last_row    = row == CW'(IMG_H - 1);
    assign tap_next    = accept & (row >= CW'(2));
    assign win_next    = tap_next & (col >= CW'(2));
    assign drain_done  = fifo0_empty & fifo1_empty & !fifo1_wr_en;
    assign fifo0_wr_en = accept;
    // DRAIN pops whatever is left; otherwise rows above the current one are read in lockstep
    assign fifo0_rd_en = state == DRAIN ? !fifo0_empty : accept & (row >= CW'(1));
    assign fifo1_rd_en = state == DRAIN ? !fifo1_empty : accept & (row >= CW'(2));
    assign busy        = state != IDLE;
    assign err_set     = abort | (fifo0_wr_en & fifo0_full) | (fifo0_rd_en & fifo0_empty)
                       | (fifo1_wr_en & fifo1_full) | (fifo1_rd_en & fifo1_empty);

    // Frame FSM, pixel counters, delayed FIFO write and registered window outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= DRAIN;
            row         <= '0;
            col         <= '0;
            fifo1_wr_en <= 1'b0;
            tap_valid   <= 1'b0;
            win_valid   <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            err         <= 1'b0;
        end else begin
            fifo1_wr_en <= accept & (row >= CW'(1));
            tap_valid   <= tap_next;
            win_valid   <= win_next;
            eol         <= win_next & last_col;
            eof         <= win_next & last_col & last_row;
            err         <= (err & !(accept & (state == IDLE))) | err_set;
            if (tap_next) begin
                win_row <= row - CW'(1);
                win_col <= col - CW'(1);
            end
            if (abort) begin
                state <= DRAIN;
                row   <= '0;
                col   <= '0;
            end else if (accept) begin
                if (last_col && last_row) begin
                    state <= DRAIN;
                    row   <= '0;
                    col   <= '0;
                end else if (last_col) begin
                    col   <= '0;
                    row   <= row + CW'(1);
                    state <= row == '0 ? ROW1 : STREAM;
                end else begin
                    col <= col + CW'(1);
                    if (state == IDLE) state <= ROW0;
                end
            end else if (state == DRAIN && drain_done) begin
                state <= IDLE;
            end
        end
    end
endmodule
